// File: rtl/iommu_pdtc_assoc_pkg.sv
// Shared types for the IOMMU process-directory context cache.
package iommu_pdtc_pkg;

   localparam int PDTC_CTX_W = 60;

   typedef enum logic {
      PDTC_LOOKUP = 1'b0,
      PDTC_FILL   = 1'b1
   } pdtc_op_e;

   typedef enum logic [1:0] {
      FLUSH_ALL      = 2'd0,
      FLUSH_DEVICE   = 2'd1,
      FLUSH_DEV_PROC = 2'd2,
      FLUSH_RSVD     = 2'd3
   } pdtc_flush_mode_e;

   typedef struct packed {
      logic        ens;
      logic        sum;
      logic [19:0] pscid;
      logic [3:0]  fsc_mode;
      logic [33:0] fsc_ppn;
   } pdtc_ctx_t;

endpackage

// File: rtl/iommu_pdtc_assoc_if.sv
// Request, response, flush and statistics bundle of the PDT context cache.
interface iommu_pdtc_assoc_if
   import iommu_pdtc_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int DID_W   = 24,
   parameter int PID_W   = 20,
   parameter int CNT_W   = 32
);
   logic                       req_valid;
   logic                       req_ready;
   logic                       req_op;
   logic [DID_W-1:0]           req_device_id;
   logic [PID_W-1:0]           req_process_id;
   pdtc_ctx_t                  req_ctx;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic                       rsp_hit;
   pdtc_ctx_t                  rsp_ctx;
   logic                       flush_valid;
   logic                       flush_ready;
   logic [1:0]                 flush_mode;
   logic [DID_W-1:0]           flush_device_id;
   logic [PID_W-1:0]           flush_process_id;
   logic                       flush_done;
   logic [$clog2(ENTRIES):0]   occupancy;
   logic [CNT_W-1:0]           hit_cnt;
   logic [CNT_W-1:0]           miss_cnt;

   modport master (
      output req_valid, req_op, req_device_id, req_process_id, req_ctx,
      output rsp_ready,
      output flush_valid, flush_mode, flush_device_id, flush_process_id,
      input  req_ready, rsp_valid, rsp_hit, rsp_ctx,
      input  flush_ready, flush_done, occupancy, hit_cnt, miss_cnt
   );

   modport slave (
      input  req_valid, req_op, req_device_id, req_process_id, req_ctx,
      input  rsp_ready,
      input  flush_valid, flush_mode, flush_device_id, flush_process_id,
      output req_ready, rsp_valid, rsp_hit, rsp_ctx,
      output flush_ready, flush_done, occupancy, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/iommu_pdtc_assoc_plru_tree.sv
// Tree pseudo-LRU: one bit per internal node, each pointing at its
// less recently used subtree (0 = left).
module iommu_plru_tree #(
   parameter int ENTRIES = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       touch_valid,
   input  logic [$clog2(ENTRIES)-1:0] touch_idx,
   output logic [$clog2(ENTRIES)-1:0] victim_idx
);
   localparam int LG = $clog2(ENTRIES);

   logic [ENTRIES-1:1] r_tree;
   logic [LG:0]        w_walk;
   logic [LG-1:0]      w_node [LG];

   // heap numbering: root is node 1, children of n are 2n and 2n+1
   always_comb begin
      w_walk = (LG+1)'(1);
      for (int l = 0; l < LG; l++) begin
         w_walk    = {w_walk[LG-1:0], r_tree[w_walk[LG-1:0]]};
         w_node[l] = LG'({1'b1, touch_idx} >> (LG - l));
      end
      victim_idx = w_walk[LG-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tree <= '0;
      end else if (touch_valid) begin
         for (int l = 0; l < LG; l++)
            r_tree[w_node[l]] <= ~touch_idx[LG-1-l];
      end
   end
endmodule

// File: rtl/iommu_pdtc_assoc.sv
// Fully associative PDT context cache with tree-PLRU replacement
// and global / per-device / per-process flush.
module iommu_pdtc_assoc
   import iommu_pdtc_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int DID_W   = 24,
   parameter int PID_W   = 20,
   parameter int CNT_W   = 32
) (
   input logic               clk,
   input logic               rst_n,
   iommu_pdtc_assoc_if.slave bus
);
   localparam int LG = $clog2(ENTRIES);

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_FDONE} state_e;

   state_e             r_state;
   logic [ENTRIES-1:0] r_valid;
   logic [DID_W-1:0]   r_did [ENTRIES];
   logic [PID_W-1:0]   r_pid [ENTRIES];
   pdtc_ctx_t          r_ctx [ENTRIES];
   logic               r_rsp_valid;
   logic               r_rsp_hit;
   pdtc_ctx_t          r_rsp_ctx;
   logic               r_fdone;
   logic [CNT_W-1:0]   r_hit_cnt;
   logic [CNT_W-1:0]   r_miss_cnt;

   logic [ENTRIES-1:0] w_match;
   logic [ENTRIES-1:0] w_fmatch;
   logic               w_hit;
   logic               w_has_free;
   logic               w_acc;
   logic               w_facc;
   logic               w_fill;
   logic               w_touch;
   logic [LG-1:0]      w_hit_idx;
   logic [LG-1:0]      w_free_idx;
   logic [LG-1:0]      w_victim;
   logic [LG-1:0]      w_fill_idx;
   logic [LG-1:0]      w_touch_idx;
   logic [LG:0]        w_occ;

   // descending scan so the lowest free index wins
   always_comb begin
      w_match    = '0;
      w_hit_idx  = '0;
      w_free_idx = '0;
      w_has_free = 1'b0;
      w_occ      = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         w_match[i] = r_valid[i] &&
                      r_did[i] == bus.req_device_id &&
                      r_pid[i] == bus.req_process_id;
         if (w_match[i])
            w_hit_idx = LG'(i);
         if (!r_valid[i]) begin
            w_has_free = 1'b1;
            w_free_idx = LG'(i);
         end
         w_occ = w_occ + (LG+1)'(r_valid[i]);
      end
      w_hit = |w_match;
   end

   always_comb begin
      w_fmatch = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         case (bus.flush_mode)
            FLUSH_DEVICE:
               w_fmatch[i] = r_did[i] == bus.flush_device_id;
            FLUSH_DEV_PROC:
               w_fmatch[i] = r_did[i] == bus.flush_device_id &&
                             r_pid[i] == bus.flush_process_id;
            default:
               w_fmatch[i] = 1'b1;
         endcase
      end
   end

   assign w_facc = (r_state == S_IDLE) && bus.flush_valid;
   assign w_acc  = (r_state == S_IDLE) && bus.req_valid && !bus.flush_valid;
   assign w_fill = bus.req_op == PDTC_FILL;
   assign w_fill_idx  = w_hit ? w_hit_idx :
                        w_has_free ? w_free_idx : w_victim;
   assign w_touch     = w_acc && (w_fill || w_hit);
   assign w_touch_idx = w_fill ? w_fill_idx : w_hit_idx;

   iommu_plru_tree #(.ENTRIES(ENTRIES)) u_plru (
      .clk         (clk),
      .rst_n       (rst_n),
      .touch_valid (w_touch),
      .touch_idx   (w_touch_idx),
      .victim_idx  (w_victim)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_did[i] <= '0;
            r_pid[i] <= '0;
            r_ctx[i] <= '0;
         end
      end else if (w_acc && w_fill) begin
         r_did[w_fill_idx] <= bus.req_device_id;
         r_pid[w_fill_idx] <= bus.req_process_id;
         r_ctx[w_fill_idx] <= bus.req_ctx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_valid     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_hit   <= 1'b0;
         r_rsp_ctx   <= '0;
         r_fdone     <= 1'b0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_fdone <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_facc) begin
                  r_valid <= r_valid & ~w_fmatch;
                  r_fdone <= 1'b1;
                  r_state <= S_FDONE;
               end else if (w_acc) begin
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
                  if (w_fill) begin
                     r_valid[w_fill_idx] <= 1'b1;
                     r_rsp_hit <= 1'b0;
                     r_rsp_ctx <= '0;
                  end else begin
                     r_rsp_hit <= w_hit;
                     r_rsp_ctx <= w_hit ? r_ctx[w_hit_idx] : '0;
                     if (w_hit && !(&r_hit_cnt))
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                     if (!w_hit && !(&r_miss_cnt))
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                  end
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_FDONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = (r_state == S_IDLE) && !bus.flush_valid;
   assign bus.flush_ready = r_state == S_IDLE;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_hit     = r_rsp_hit;
   assign bus.rsp_ctx     = r_rsp_ctx;
   assign bus.flush_done  = r_fdone;
   assign bus.occupancy   = w_occ;
   assign bus.hit_cnt     = r_hit_cnt;
   assign bus.miss_cnt    = r_miss_cnt;
endmodule

// File: tb/tb_iommu_pdtc_assoc.sv
// Directed plus randomized bench for iommu_pdtc_assoc with a
// timestamp-based pseudo-LRU reference model.
module tb_iommu_pdtc_assoc;
  import iommu_pdtc_pkg::*;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  iommu_pdtc_assoc_if bus ();

  iommu_pdtc_assoc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] o,
                     input logic [63:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  logic                  m_v   [N];
  logic [23:0]           m_did [N];
  logic [19:0]           m_pid [N];
  logic [PDTC_CTX_W-1:0] m_ctx [N];
  int                    m_ts  [N];
  int                    m_t;
  logic [31:0]           m_hits;
  logic [31:0]           m_miss;
  logic                  last_hit;
  logic [PDTC_CTX_W-1:0] last_ctx;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_ts[i] = 0;
    end
    m_t = 0;
    m_hits = '0;
    m_miss = '0;
  endfunction

  function automatic int m_find(logic [23:0] d,
                                logic [19:0] p);
    for (int i = 0; i < N; i++)
      if (m_v[i] && m_did[i] == d && m_pid[i] == p)
        return i;
    return -1;
  endfunction

  function automatic int m_victim();
    int lo = 0;
    int sz = N;
    int ml;
    int mr;
    while (sz > 1) begin
      sz = sz / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < sz; i++) begin
        if (m_ts[lo+i] > ml) ml = m_ts[lo+i];
        if (m_ts[lo+sz+i] > mr) mr = m_ts[lo+sz+i];
      end
      if (mr < ml) lo = lo + sz;
    end
    return lo;
  endfunction

  function automatic void m_touch(int i);
    m_t++;
    m_ts[i] = m_t;
  endfunction

  function automatic logic [3:0] m_occ();
    logic [3:0] c = '0;
    for (int i = 0; i < N; i++) c = c + 4'(m_v[i]);
    return c;
  endfunction

  function automatic void m_flush(logic [1:0] md,
                                  logic [23:0] d,
                                  logic [19:0] p);
    for (int i = 0; i < N; i++) begin
      if (md == 2'd1 && m_did[i] != d) continue;
      if (md == 2'd2 &&
          (m_did[i] != d || m_pid[i] != p)) continue;
      m_v[i] = 1'b0;
    end
  endfunction

  task automatic do_req(input logic op,
                        input logic [23:0] d,
                        input logic [19:0] p,
                        input logic [PDTC_CTX_W-1:0] c,
                        input int hold);
    logic                  eh;
    logic [PDTC_CTX_W-1:0] ec;
    int                    k;
    int                    idx;
    bus.req_valid      = 1'b1;
    bus.req_op         = op;
    bus.req_device_id  = d;
    bus.req_process_id = p;
    bus.req_ctx        = c;
    bus.rsp_ready      = (hold == 0);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_wait", k < 20, 1'b1);
    chk("req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    idx = m_find(d, p);
    eh = 1'b0;
    ec = '0;
    if (op == 1'b1) begin
      if (idx < 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (!m_v[i]) idx = i;
        if (idx < 0) idx = m_victim();
      end
      m_v[idx] = 1'b1;
      m_did[idx] = d;
      m_pid[idx] = p;
      m_ctx[idx] = c;
      m_touch(idx);
    end else if (idx >= 0) begin
      eh = 1'b1;
      ec = m_ctx[idx];
      m_touch(idx);
      m_hits++;
    end else begin
      m_miss++;
    end
    last_hit = bus.rsp_hit;
    last_ctx = bus.rsp_ctx;
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_hit", last_hit, eh);
    chk("rsp_ctx", last_ctx, ec);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      last_ctx = bus.rsp_ctx;
      chk("stall_valid", bus.rsp_valid, 1'b1);
      chk("stall_hit", bus.rsp_hit, eh);
      chk("stall_ctx", last_ctx, ec);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_drop", bus.rsp_valid, 1'b0);
    chk("occupancy", bus.occupancy, m_occ());
    chk("hit_cnt", bus.hit_cnt, m_hits);
    chk("miss_cnt", bus.miss_cnt, m_miss);
  endtask

  task automatic do_flush(input logic [1:0] md,
                          input logic [23:0] d,
                          input logic [19:0] p);
    int k;
    bus.flush_valid      = 1'b1;
    bus.flush_mode       = md;
    bus.flush_device_id  = d;
    bus.flush_process_id = p;
    k = 0;
    while (!bus.flush_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("flush_wait", k < 20, 1'b1);
    chk("flush_ready", bus.flush_ready, 1'b1);
    @(posedge clk); #1;
    bus.flush_valid = 1'b0;
    m_flush(md, d, p);
    chk("flush_done", bus.flush_done, 1'b1);
    chk("flush_occ", bus.occupancy, m_occ());
    @(posedge clk); #1;
    chk("flush_pulse", bus.flush_done, 1'b0);
  endtask

  logic [PDTC_CTX_W-1:0] rc;
  int                    sel;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 1'b0;
    bus.req_device_id = '0;
    bus.req_process_id = '0;
    bus.req_ctx = '0;
    bus.rsp_ready = 1'b1;
    bus.flush_valid = 1'b0;
    bus.flush_mode = 2'd0;
    bus.flush_device_id = '0;
    bus.flush_process_id = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_flush_done", bus.flush_done, 1'b0);
    chk("rst_occ", bus.occupancy, 4'd0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_flush_ready", bus.flush_ready, 1'b1);
    chk("rst_hit_cnt", bus.hit_cnt, 32'd0);

    do_req(1'b0, 24'h000123, 20'h00045, '0, 0);
    chk("first_miss", last_hit, 1'b0);

    for (int i = 0; i < N; i++) begin
      rc = {$urandom, $urandom};
      do_req(1'b1, 24'h100 + 24'(i),
             20'h200 + 20'(i), rc, 0);
    end
    for (int i = 0; i < N; i++)
      do_req(1'b0, 24'h100 + 24'(i),
             20'h200 + 20'(i), '0, 0);
    chk("full_occ", bus.occupancy, 4'd8);
    chk("eight_hits", bus.hit_cnt, 32'd8);

    for (int i = 6; i >= 0; i--)
      do_req(1'b0, 24'h100 + 24'(i),
             20'h200 + 20'(i), '0, 0);
    do_req(1'b1, 24'h999, 20'h999,
           {$urandom, $urandom}, 0);
    chk("evict_occ", bus.occupancy, 4'd8);
    do_req(1'b0, 24'h107, 20'h207, '0, 0);
    chk("evict7_miss", last_hit, 1'b0);

    rc = {1'b1, 1'b0, 20'h12345, 4'h8,
          34'h3_0000_0001};
    do_req(1'b1, 24'h100, 20'h200, rc, 0);
    chk("refill_occ", bus.occupancy, 4'd8);
    do_req(1'b0, 24'h100, 20'h200, '0, 0);
    chk("refill_hit", last_hit, 1'b1);
    chk("refill_ppn", last_ctx[33:0],
        34'h3_0000_0001);

    do_flush(2'd0, '0, '0);
    do_req(1'b1, 24'd5, 20'd1, {$urandom, $urandom}, 0);
    do_req(1'b1, 24'd5, 20'd2, {$urandom, $urandom}, 0);
    do_req(1'b1, 24'd6, 20'd1, {$urandom, $urandom}, 0);
    do_flush(2'd1, 24'd5, '0);
    chk("dev_flush_occ", bus.occupancy, 4'd1);
    do_req(1'b0, 24'd5, 20'd1, '0, 0);
    chk("dev_5_1", last_hit, 1'b0);
    do_req(1'b0, 24'd5, 20'd2, '0, 0);
    chk("dev_5_2", last_hit, 1'b0);
    do_req(1'b0, 24'd6, 20'd1, '0, 0);
    chk("dev_6_1", last_hit, 1'b1);

    bus.flush_valid = 1'b1;
    bus.flush_mode = 2'd2;
    bus.flush_device_id = 24'd7;
    bus.flush_process_id = 20'd7;
    bus.req_valid = 1'b1;
    bus.req_op = 1'b0;
    bus.req_device_id = 24'd6;
    bus.req_process_id = 20'd1;
    #1;
    chk("prio_req_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    bus.flush_valid = 1'b0;
    m_flush(2'd2, 24'd7, 20'd7);
    chk("prio_flush_done", bus.flush_done, 1'b1);
    chk("prio_no_rsp", bus.rsp_valid, 1'b0);
    do_req(1'b0, 24'd6, 20'd1, '0, 3);
    chk("prio_hit", last_hit, 1'b1);

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)
        do_flush(2'($urandom_range(0, 3)),
                 24'($urandom_range(0, 3)),
                 20'($urandom_range(0, 3)));
      else
        do_req(sel < 6, 24'($urandom_range(0, 3)),
               20'($urandom_range(0, 3)),
               {$urandom, $urandom},
               int'($urandom_range(0, 2)));
    end

    bus.req_valid = 1'b1;
    bus.req_op = 1'b0;
    bus.req_device_id = 24'd1;
    bus.req_process_id = 20'd1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_rsp", bus.rsp_valid, 1'b0);
    chk("mid_rst_occ", bus.occupancy, 4'd0);
    chk("mid_rst_miss", bus.miss_cnt, 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_rsp", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 24'd1, 20'd1, '0, 0);
    chk("post_rst_miss", last_hit, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
